banked_regfile: RTL and testbench
=================================

# banked_regfile

Parametrised successor to the 8-bit CPU register file. It holds the accumulator, stack pointer, general registers and a pair of link registers (DX/DY) banked against interrupt shadow copies. It owns the interrupt-status state machine (NORMAL/INT) and a handshaked byte I/O port. It sits between the decoder/ALU and the memory interface, and is driven once per instruction-execute cycle.

## Interface
- WIDTH, 8: data width of every register; return addresses are 2*WIDTH.
- NREG, 4: number of architectural registers; power of 2, ≥4; SEL_W = log2(NREG).
- clk  in  1  system clock; all state updates on rising edge.
- nclr  in  1  reset, synchronous, active-low.
- rd / wr  in  1  rd-mode: acc ← reg[rs]; wr-mode: reg[rs] ← acc.
- wa  in  1  acc ← aluout.
- isp  in  1  sp ← aluout.
- ljr  in  1  link pair ← ra (jump-and-link).
- rs  in  SEL_W  register select.
- ra  in  2*WIDTH  jump return address.
- aluout  in  WIDTH  ALU result.
- ienabled, int_req, int_ret  in  1  interrupt enable, request, return.
- intra  in  2*WIDTH  interrupt return address.
- iow, ior  in  1  I/O write (io_out ← acc) and I/O read (acc ← io_in).
- io_ready  in  1  consumer accepts io_out.
- io_in  in  WIDTH  input data.
- io_in_valid  in  1  io_in is valid.
- acc, sp, dx, dy, rdata  out  WIDTH  register contents; dx/dy are the active bank; rdata = reg[rs].
- istatus  out  1  1 while in INT state.
- io_out  out  WIDTH  output data register.
- io_valid  out  1  io_out holds unconsumed data.
- stall  out  1  current I/O op cannot complete; decoder must hold the instruction.

## Operation
- Register map: 0 = acc, 1 = sp, 2..NREG-3 = general, NREG-2 = dx, NREG-1 = dy.
- acc priority: accepted ior > rd > wa. wr with rs=0 is a no-op.
- sp priority: wr with rs=1 > isp.
- General registers are written only by wr.
- Link registers are written by wr (rs = dx/dy) or by ljr (dx ← ra[WIDTH-1:0], dy ← ra[2W-1:W]); wr wins on the selected register.
- Writes go to the main bank in NORMAL and to the alt bank in INT. dx/dy/rdata read the bank selected by istatus.
- State machine:
  - NORMAL → INT when int_req & ienabled.
  - INT → NORMAL when int_ret.
  - int_req is ignored in INT (no nesting); int_ret is ignored in NORMAL.
  - int_ret and int_req in the same INT cycle: → NORMAL; entry is taken no earlier than the next cycle.
- Alt bank capture: every NORMAL cycle with ienabled=1, alt dx/dy ← intra. Capture freezes on entry, so alt holds intra of the entry cycle. A same-cycle ljr still writes the main bank.
- I/O out: iow with (!io_valid | io_ready) loads io_out ← acc and sets io_valid. io_ready with no new iow clears io_valid.
- I/O in: ior with io_in_valid loads acc ← io_in.
- stall = (iow & io_valid & !io_ready) | (ior & !io_in_valid). This is combinational; a stalled op changes no state.

## Timing
- Every write is visible on its output the cycle after the enabling edge. All outputs are registered except rdata, dx, dy (mux of registers) and stall.
- istatus rises the cycle after int_req is sampled and falls the cycle after int_ret.
- Reset (synchronous, takes effect at the next edge even mid-operation): all registers, both banks and io_out = 0; state NORMAL; io_valid = 0. Pending I/O is discarded.
- Back-to-back iow with io_ready held high sustains one transfer per cycle.

## Configuration
- BANKED_REGFILE_IO_EN defined: I/O port and stall logic as above.
- Not defined: io_out = 0, io_valid = 0, stall = 0; iow/ior/io_ready/io_in/io_in_valid are ignored; acc priority reduces to rd > wa.

## Test plan
- Reset, then wa with aluout=0x3C, then wr rs=2 → acc=0x3C; next cycle reg2: rd rs=2 gives acc=0x3C; sp=dx=dy=0.
- ljr ra=0x1234 in NORMAL → dx=0x34, dy=0x12, istatus=0.
- ienabled=1, intra=0xBEEF, int_req → istatus=1, dx=0xEF, dy=0xBE. Then ljr ra=0x5555 writes alt only. Then int_ret → dx/dy=0x34/0x12 restored.
- In INT, int_req and int_ret together → istatus=0 next cycle, 0 the cycle after if int_req dropped.
- acc=0xA5, iow with io_ready=0 → io_valid=1, io_out=0xA5. Second iow → stall=1 and io_out unchanged. io_ready=1 → accepted; io_out=new acc.
- ior with io_in_valid=0 → stall=1, acc unchanged. Then io_in_valid=1, io_in=0x7E together with wa → acc=0x7E.

Source files
------------

// File: rtl/banked_regfile.sv
// banked_regfile: CPU register file with an interrupt-banked dx/dy link pair, NORMAL/INT
// status FSM and a handshaked I/O port (compiled in when BANKED_REGFILE_IO_EN is defined).
module banked_regfile #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int SEL_W = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               nclr,
  input  logic               rd,
  input  logic               wr,
  input  logic               wa,
  input  logic               isp,
  input  logic               ljr,
  input  logic [SEL_W-1:0]   rs,
  input  logic [2*WIDTH-1:0] ra,
  input  logic [WIDTH-1:0]   aluout,
  input  logic               ienabled,
  input  logic               int_req,
  input  logic               int_ret,
  input  logic [2*WIDTH-1:0] intra,
  input  logic               iow,
  input  logic               ior,
  input  logic               io_ready,
  input  logic [WIDTH-1:0]   io_in,
  input  logic               io_in_valid,
  output logic [WIDTH-1:0]   acc,
  output logic [WIDTH-1:0]   sp,
  output logic [WIDTH-1:0]   dx,
  output logic [WIDTH-1:0]   dy,
  output logic [WIDTH-1:0]   rdata,
  output logic               istatus,
  output logic [WIDTH-1:0]   io_out,
  output logic               io_valid,
  output logic               stall
);

  typedef enum logic {ST_NORMAL = 1'b0, ST_INT = 1'b1} state_e;

  localparam logic [SEL_W-1:0] IDX_SP = SEL_W'(1);
  localparam logic [SEL_W-1:0] IDX_DX = SEL_W'(NREG - 2);
  localparam logic [SEL_W-1:0] IDX_DY = SEL_W'(NREG - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] alt_dx_q, alt_dx_d;
  logic [WIDTH-1:0] alt_dy_q, alt_dy_d;
  logic [WIDTH-1:0] io_out_q, io_out_d;
  logic             io_valid_q, io_valid_d;

  logic             in_int_s;
  logic [WIDTH-1:0] dx_s, dy_s, rdata_s;
  logic             stall_s, iow_ok_s, ior_ok_s, io_ready_s;

`ifdef BANKED_REGFILE_IO_EN
  assign stall_s    = (iow & io_valid_q & ~io_ready) | (ior & ~io_in_valid);
  assign iow_ok_s   = iow & (~io_valid_q | io_ready) & ~stall_s;
  assign ior_ok_s   = ior & io_in_valid & ~stall_s;
  assign io_ready_s = io_ready;
`else
  logic unused_io_s;
  assign unused_io_s = ^{iow, ior, io_ready, io_in_valid};
  assign stall_s     = 1'b0;
  assign iow_ok_s    = 1'b0;
  assign ior_ok_s    = 1'b0;
  assign io_ready_s  = 1'b0;
`endif

  // Slots 0/1 of regs_q are acc/sp; the top two slots are the main-bank link pair.
  assign in_int_s = (state_q == ST_INT);
  assign dx_s     = in_int_s ? alt_dx_q : regs_q[NREG-2];
  assign dy_s     = in_int_s ? alt_dy_q : regs_q[NREG-1];

  // Read port: link slots follow the bank selected by istatus.
  always_comb begin
    rdata_s = regs_q[rs];
    if (rs == IDX_DX) begin
      rdata_s = dx_s;
    end else if (rs == IDX_DY) begin
      rdata_s = dy_s;
    end else begin
      rdata_s = regs_q[rs];
    end
  end

  // Next-state: a stalled instruction is held entirely, only the output handshake advances.
  always_comb begin
    regs_d     = regs_q;
    alt_dx_d   = alt_dx_q;
    alt_dy_d   = alt_dy_q;
    state_d    = state_q;
    io_out_d   = io_out_q;
    io_valid_d = io_valid_q;

    if (!stall_s) begin
      if (ior_ok_s) begin
        regs_d[0] = io_in;
      end else if (rd) begin
        regs_d[0] = rdata_s;
      end else if (wa) begin
        regs_d[0] = aluout;
      end else begin
        regs_d[0] = regs_q[0];
      end

      if (wr && (rs == IDX_SP)) begin
        regs_d[1] = regs_q[0];
      end else if (isp) begin
        regs_d[1] = aluout;
      end else begin
        regs_d[1] = regs_q[1];
      end

      for (int i = 2; i < NREG - 2; i++) begin
        if (wr && (rs == SEL_W'(i))) begin
          regs_d[i] = regs_q[0];
        end else begin
          regs_d[i] = regs_q[i];
        end
      end

      if (in_int_s) begin
        if (wr && (rs == IDX_DX)) begin
          alt_dx_d = regs_q[0];
        end else if (ljr) begin
          alt_dx_d = ra[WIDTH-1:0];
        end else begin
          alt_dx_d = alt_dx_q;
        end
        if (wr && (rs == IDX_DY)) begin
          alt_dy_d = regs_q[0];
        end else if (ljr) begin
          alt_dy_d = ra[2*WIDTH-1:WIDTH];
        end else begin
          alt_dy_d = alt_dy_q;
        end
      end else begin
        if (wr && (rs == IDX_DX)) begin
          regs_d[NREG-2] = regs_q[0];
        end else if (ljr) begin
          regs_d[NREG-2] = ra[WIDTH-1:0];
        end else begin
          regs_d[NREG-2] = regs_q[NREG-2];
        end
        if (wr && (rs == IDX_DY)) begin
          regs_d[NREG-1] = regs_q[0];
        end else if (ljr) begin
          regs_d[NREG-1] = ra[2*WIDTH-1:WIDTH];
        end else begin
          regs_d[NREG-1] = regs_q[NREG-1];
        end
        // Alt bank tracks intra until entry, so it freezes on the entry cycle's value.
        if (ienabled) begin
          alt_dx_d = intra[WIDTH-1:0];
          alt_dy_d = intra[2*WIDTH-1:WIDTH];
        end else begin
          alt_dx_d = alt_dx_q;
          alt_dy_d = alt_dy_q;
        end
      end

      case (state_q)
        ST_NORMAL: begin
          if (int_req && ienabled) begin
            state_d = ST_INT;
          end else begin
            state_d = ST_NORMAL;
          end
        end
        ST_INT: begin
          if (int_ret) begin
            state_d = ST_NORMAL;
          end else begin
            state_d = ST_INT;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end else begin
      state_d = state_q;
    end

    if (iow_ok_s) begin
      io_out_d   = regs_q[0];
      io_valid_d = 1'b1;
    end else if (io_ready_s) begin
      io_valid_d = 1'b0;
    end else begin
      io_valid_d = io_valid_q;
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!nclr) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      alt_dx_q   <= {WIDTH{1'b0}};
      alt_dy_q   <= {WIDTH{1'b0}};
      io_out_q   <= {WIDTH{1'b0}};
      io_valid_q <= 1'b0;
      state_q    <= ST_NORMAL;
    end else begin
      regs_q     <= regs_d;
      alt_dx_q   <= alt_dx_d;
      alt_dy_q   <= alt_dy_d;
      io_out_q   <= io_out_d;
      io_valid_q <= io_valid_d;
      state_q    <= state_d;
    end
  end

  assign acc      = regs_q[0];
  assign sp       = regs_q[1];
  assign dx       = dx_s;
  assign dy       = dy_s;
  assign rdata    = rdata_s;
  assign istatus  = in_int_s;
  assign io_out   = io_out_q;
  assign io_valid = io_valid_q;
  assign stall    = stall_s;

endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed scenarios plus randomized traffic against a behavioural model
// of banked_regfile (I/O checks follow BANKED_REGFILE_IO_EN).
module tb_banked_regfile;
  localparam int WIDTH = 8;
  localparam int NREG  = 8;
  localparam int SEL_W = 3;
`ifdef BANKED_REGFILE_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nclr, rd, wr, wa, isp, ljr, ienabled, int_req, int_ret;
  logic iow, ior, io_ready, io_in_valid;
  logic [SEL_W-1:0] rs;
  logic [2*WIDTH-1:0] ra, intra;
  logic [WIDTH-1:0] aluout, io_in;
  logic [WIDTH-1:0] acc, sp, dx, dy, rdata, io_out;
  logic istatus, io_valid, stall;

  banked_regfile #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk(clk), .nclr(nclr), .rd(rd), .wr(wr), .wa(wa), .isp(isp), .ljr(ljr),
    .rs(rs), .ra(ra), .aluout(aluout), .ienabled(ienabled), .int_req(int_req),
    .int_ret(int_ret), .intra(intra), .iow(iow), .ior(ior), .io_ready(io_ready),
    .io_in(io_in), .io_in_valid(io_in_valid), .acc(acc), .sp(sp), .dx(dx), .dy(dy),
    .rdata(rdata), .istatus(istatus), .io_out(io_out), .io_valid(io_valid), .stall(stall)
  );

  int checks_n = 0;
  int errors_n = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural state as plain integers; link[bank][0=dx,1=dy].
  int m_acc, m_sp, m_ioout;
  int m_gen [NREG];
  int m_link [2][2];
  bit m_int, m_iov;

  function automatic int m_read(input int idx);
    if (idx == 0) return m_acc;
    if (idx == 1) return m_sp;
    if (idx == NREG - 2) return m_link[m_int][0];
    if (idx == NREG - 1) return m_link[m_int][1];
    return m_gen[idx];
  endfunction

  function automatic bit m_stall();
    return IO_EN && ((iow && m_iov && !io_ready) || (ior && !io_in_valid));
  endfunction

  task automatic clear_in();
    nclr = 1'b1; rd = 1'b0; wr = 1'b0; wa = 1'b0; isp = 1'b0; ljr = 1'b0;
    ienabled = 1'b0; int_req = 1'b0; int_ret = 1'b0; iow = 1'b0; ior = 1'b0;
    io_ready = 1'b0; io_in_valid = 1'b0; rs = 3'd0; ra = 16'h0000;
    intra = 16'h0000; aluout = 8'h00; io_in = 8'h00;
  endtask

  // One instruction cycle: check combinational outputs, predict, clock, check registered state.
  task automatic step();
    int n_acc, n_sp, n_ioout, b, r;
    int n_gen [NREG];
    int n_link [2][2];
    bit n_int, n_iov, st;
    #1;
    check_val("rdata", rdata, m_read(int'(rs)));
    check_val("dx_comb", dx, m_link[m_int][0]);
    check_val("dy_comb", dy, m_link[m_int][1]);
    check_val("stall", stall, m_stall());
    n_acc = m_acc; n_sp = m_sp; n_ioout = m_ioout; n_gen = m_gen; n_link = m_link;
    n_int = m_int; n_iov = m_iov;
    r = int'(rs);
    if (!nclr) begin
      n_acc = 0; n_sp = 0; n_ioout = 0; n_int = 1'b0; n_iov = 1'b0;
      foreach (n_gen[i]) n_gen[i] = 0;
      foreach (n_link[i, j]) n_link[i][j] = 0;
    end else begin
      st = m_stall();
      if (!st) begin
        if (wa) n_acc = int'(aluout);
        if (rd) n_acc = m_read(r);
        if (IO_EN && ior && io_in_valid) n_acc = int'(io_in);
        if (isp) n_sp = int'(aluout);
        if (wr && r == 1) n_sp = m_acc;
        b = m_int;
        if (ljr) begin
          n_link[b][0] = int'(ra) % 256;
          n_link[b][1] = int'(ra) / 256;
        end
        if (wr && r >= 2) begin
          if (r == NREG - 2) n_link[b][0] = m_acc;
          else if (r == NREG - 1) n_link[b][1] = m_acc;
          else n_gen[r] = m_acc;
        end
        if (!m_int && ienabled) begin
          n_link[1][0] = int'(intra) % 256;
          n_link[1][1] = int'(intra) / 256;
        end
        if (m_int) n_int = !int_ret;
        else n_int = int_req && ienabled;
      end
      if (IO_EN && !st && iow && (!m_iov || io_ready)) begin
        n_ioout = m_acc;
        n_iov = 1'b1;
      end else if (IO_EN && io_ready) begin
        n_iov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_acc = n_acc; m_sp = n_sp; m_ioout = n_ioout; m_gen = n_gen; m_link = n_link;
    m_int = n_int; m_iov = n_iov;
    check_val("acc", acc, m_acc);
    check_val("sp", sp, m_sp);
    check_val("dx", dx, m_link[m_int][0]);
    check_val("dy", dy, m_link[m_int][1]);
    check_val("istatus", istatus, m_int);
    check_val("io_out", io_out, m_ioout);
    check_val("io_valid", io_valid, m_iov);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_acc = 0; m_sp = 0; m_ioout = 0; m_int = 1'b0; m_iov = 1'b0;
    foreach (m_gen[i]) m_gen[i] = 0;
    foreach (m_link[i, j]) m_link[i][j] = 0;

    clear_in(); nclr = 1'b0; step();
    check_val("rst_acc", acc, 8'h00);
    check_val("rst_istatus", istatus, 1'b0);

    clear_in(); wa = 1'b1; aluout = 8'h3C; step();
    check_val("tp_wa", acc, 8'h3C);
    clear_in(); wr = 1'b1; rs = 3'd2; step();
    clear_in(); wa = 1'b1; aluout = 8'h00; step();
    clear_in(); rd = 1'b1; rs = 3'd2; step();
    check_val("tp_rd", acc, 8'h3C);
    check_val("tp_sp0", sp, 8'h00);

    clear_in(); ljr = 1'b1; ra = 16'h1234; step();
    check_val("tp_ljr_dx", dx, 8'h34);
    check_val("tp_ljr_dy", dy, 8'h12);

    clear_in(); ienabled = 1'b1; intra = 16'hBEEF; int_req = 1'b1; step();
    check_val("tp_int_st", istatus, 1'b1);
    check_val("tp_int_dx", dx, 8'hEF);
    check_val("tp_int_dy", dy, 8'hBE);
    clear_in(); ienabled = 1'b1; intra = 16'h1111; ljr = 1'b1; ra = 16'h5555; step();
    check_val("tp_alt_ljr", dx, 8'h55);
    clear_in(); int_ret = 1'b1; step();
    check_val("tp_ret_st", istatus, 1'b0);
    check_val("tp_ret_dx", dx, 8'h34);
    check_val("tp_ret_dy", dy, 8'h12);

    clear_in(); ienabled = 1'b1; int_req = 1'b1; step();
    clear_in(); ienabled = 1'b1; int_req = 1'b1; int_ret = 1'b1; step();
    check_val("tp_reqret", istatus, 1'b0);
    clear_in(); ienabled = 1'b1; step();
    check_val("tp_reqret2", istatus, 1'b0);

`ifdef BANKED_REGFILE_IO_EN
    clear_in(); wa = 1'b1; aluout = 8'hA5; step();
    clear_in(); iow = 1'b1; step();
    check_val("tp_iow_v", io_valid, 1'b1);
    check_val("tp_iow_d", io_out, 8'hA5);
    clear_in(); wa = 1'b1; aluout = 8'h5A; step();
    clear_in(); iow = 1'b1; #1;
    check_val("tp_iow_stall", stall, 1'b1);
    step();
    check_val("tp_iow_hold", io_out, 8'hA5);
    clear_in(); iow = 1'b1; io_ready = 1'b1; step();
    check_val("tp_iow_new", io_out, 8'h5A);
    clear_in(); ior = 1'b1; #1;
    check_val("tp_ior_stall", stall, 1'b1);
    step();
    check_val("tp_ior_hold", acc, 8'h5A);
    clear_in(); ior = 1'b1; io_in_valid = 1'b1; io_in = 8'h7E; wa = 1'b1; aluout = 8'h11; step();
    check_val("tp_ior_acc", acc, 8'h7E);
`else
    clear_in(); wa = 1'b1; aluout = 8'hA5; step();
    clear_in(); iow = 1'b1; ior = 1'b1; io_in = 8'h7E; io_in_valid = 1'b1; step();
    check_val("tp_noio_acc", acc, 8'hA5);
    check_val("tp_noio_v", io_valid, 1'b0);
`endif

    for (int n = 0; n < 1500; n++) begin
      nclr        = ($urandom_range(0, 99) != 0);
      rd          = ($urandom_range(0, 5) == 0);
      wr          = ($urandom_range(0, 3) == 0);
      wa          = ($urandom_range(0, 2) == 0);
      isp         = ($urandom_range(0, 3) == 0);
      ljr         = ($urandom_range(0, 5) == 0);
      rs          = SEL_W'($urandom_range(0, NREG - 1));
      ra          = 16'($urandom());
      intra       = 16'($urandom());
      aluout      = 8'($urandom());
      ienabled    = ($urandom_range(0, 1) == 1);
      int_req     = ($urandom_range(0, 7) == 0);
      int_ret     = ($urandom_range(0, 5) == 0);
      iow         = ($urandom_range(0, 3) == 0);
      ior         = ($urandom_range(0, 3) == 0);
      io_ready    = ($urandom_range(0, 1) == 1);
      io_in_valid = ($urandom_range(0, 1) == 1);
      io_in       = 8'($urandom());
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
